// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants and state encoding for the radix-2 DIF FFT
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default transform size: N = 2**LOG2N_DEF points.
    localparam int LOG2N_DEF = 4;
    localparam int N_DEF     = 1 << LOG2N_DEF;

    // Read-to-write latency: 1 RAM read cycle + 1 butterfly register.
    localparam int WR_LAT    = 2;

    // Idle cycles between stages so the last write lands before the next read.
    localparam int DRAIN_LEN = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_addr_gen
// Description : Combinational operand/twiddle address generator for butterfly
//               j of a given stage of an in-place radix-2 DIF FFT.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_gen #(
    parameter int LOG2N = 4
) (
    input  logic [$clog2(LOG2N)-1:0] stage,
    input  logic [LOG2N-2:0]         j,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_addr
);

    localparam int NN = 1 << LOG2N;

    int span;
    int grp;
    int k;
    int base;

    // Butterfly j belongs to group g with offset k; operands are span apart.
    always_comb begin
        span    = NN >> (int'(stage) + 1);
        grp     = int'(j) >> (LOG2N - 1 - int'(stage));
        k       = int'(j) & (span - 1);
        base    = 2 * grp * span + k;
        addr_a  = LOG2N'(base);
        addr_b  = LOG2N'(base + span);
        tw_addr = (LOG2N-1)'(k << stage);
    end

endmodule
`default_nettype wire

// File: rtl/fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_ctrl
// Description : Sequencer for an in-place N-point radix-2 DIF FFT. Issues one
//               butterfly read per cycle, drains between stages and replays
//               the read addresses as write addresses WR_LAT cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b,
    output logic [$clog2(LOG2N)-1:0] stage
);

    localparam int                  SW         = $clog2(LOG2N);
    localparam int                  JW         = LOG2N - 1;
    localparam int                  DCW        = $clog2(DRAIN_LEN);
    localparam logic [JW-1:0]       J_LAST     = '1;
    localparam logic [SW-1:0]       STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [DCW-1:0]      DRAIN_LAST = DCW'(DRAIN_LEN - 1);

    fsm_state_t      state, state_nx;
    logic [SW-1:0]   stage_q, stage_nx;
    logic [JW-1:0]   j_q, j_nx;
    logic [DCW-1:0]  dcnt_q, dcnt_nx;

    logic [LOG2N-1:0] gen_a, gen_b;
    logic [LOG2N-2:0] gen_tw;

    logic             pipe_en [WR_LAT];
    logic [LOG2N-1:0] pipe_a  [WR_LAT];
    logic [LOG2N-1:0] pipe_b  [WR_LAT];

    fft_addr_gen #(
        .LOG2N   (LOG2N)
    ) u_addr_gen (
        .stage   (stage_q),
        .j       (j_q),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_tw)
    );

    // State, stage, butterfly index and drain counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state   <= state_nx;
            stage_q <= stage_nx;
            j_q     <= j_nx;
            dcnt_q  <= dcnt_nx;
        end
    end

    // Next-state logic: RUN walks j, DRAIN waits, then next stage or DONE.
    always_comb begin
        state_nx = state;
        stage_nx = stage_q;
        j_nx     = j_q;
        dcnt_nx  = dcnt_q;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                    stage_nx = '0;
                    j_nx     = '0;
                end
            end
            ST_RUN: begin
                if (j_q == J_LAST) begin
                    state_nx = ST_DRAIN;
                    j_nx     = '0;
                    dcnt_nx  = '0;
                end else begin
                    j_nx = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DRAIN_LAST) begin
                    j_nx = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_RUN;
                        stage_nx = stage_q + 1'b1;
                    end
                end else begin
                    dcnt_nx = dcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                stage_nx = '0;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read-side outputs; addresses are forced to zero outside RUN.
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign rd_en     = (state == ST_RUN);
    assign rd_addr_a = rd_en ? gen_a  : '0;
    assign rd_addr_b = rd_en ? gen_b  : '0;
    assign tw_addr   = rd_en ? gen_tw : '0;
    assign stage     = stage_q;

    // Write-address delay line; zeros shift through when no read was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WR_LAT; i++) begin
                pipe_en[i] <= 1'b0;
                pipe_a[i]  <= '0;
                pipe_b[i]  <= '0;
            end
        end else begin
            pipe_en[0] <= rd_en;
            pipe_a[0]  <= rd_addr_a;
            pipe_b[0]  <= rd_addr_b;
            for (int i = 1; i < WR_LAT; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_a[i]  <= pipe_a[i-1];
                pipe_b[i]  <= pipe_b[i-1];
            end
        end
    end

    assign wr_en     = pipe_en[WR_LAT-1];
    assign wr_addr_a = pipe_a[WR_LAT-1];
    assign wr_addr_b = pipe_b[WR_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_ctrl
// Description : Scoreboard bench for fft_ctrl with an FFT loop-nest reference,
//               RAM/butterfly model and DFT reference for end-to-end runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_ctrl;

    localparam int  LOG2N     = 4;
    localparam int  N         = 1 << LOG2N;
    localparam int  HALF      = N / 2;
    localparam int  LAT       = 2;
    localparam int  STAGE_CYC = HALF + 2;
    localparam int  RUN_CYC   = LOG2N * STAGE_CYC + 1;
    localparam int  SW        = $clog2(LOG2N);
    localparam real PI        = 3.14159265358979323846;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, rd_en, wr_en;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic [SW-1:0]    stage;

    fft_ctrl #(.LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input int got, input int want, input int tol);
        checks++;
        if (got - want > tol || want - got > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, got, want, tol);
        end
    endtask

    // ---------------- reference model: expected per-cycle outputs ----------
    typedef struct {
        int cyc;
        bit busy;
        bit done;
        bit rd;
        int a;
        int b;
        int tw;
        int st;
        bit wr;
        int wa;
        int wb;
    } exp_t;

    exp_t exp_q[$];
    int   next_free = 0;

    // Classic DIF loop nest: stage s, group g, butterfly k within group.
    task automatic predict(input int t0);
        exp_t r[RUN_CYC+1];
        int   c, span, ngrp;
        for (int i = 0; i <= RUN_CYC; i++) begin
            r[i] = '{default: 0};
            r[i].cyc = t0 + i;
        end
        for (int s = 0; s < LOG2N; s++) begin
            span = N >> (s + 1);
            ngrp = N / (2 * span);
            c    = 1 + s * STAGE_CYC;
            for (int i = 0; i < STAGE_CYC; i++) begin
                r[c+i].busy = 1'b1;
                r[c+i].st   = s;
            end
            for (int g = 0; g < ngrp; g++) begin
                for (int k = 0; k < span; k++) begin
                    r[c].rd = 1'b1;
                    r[c].a  = g * 2 * span + k;
                    r[c].b  = g * 2 * span + k + span;
                    r[c].tw = k * ngrp;
                    r[c+LAT].wr = 1'b1;
                    r[c+LAT].wa = r[c].a;
                    r[c+LAT].wb = r[c].b;
                    c++;
                end
            end
        end
        r[RUN_CYC].done = 1'b1;
        for (int i = 1; i <= RUN_CYC; i++) exp_q.push_back(r[i]);
    endtask

    // Monitor: compares DUT outputs every cycle, then predicts on accepted start.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                next_free = 0;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
            else                                          e = '{default: 0};
            chk("busy",      busy,      e.busy);
            chk("done",      done,      e.done);
            chk("rd_en",     rd_en,     e.rd);
            chk("rd_addr_a", rd_addr_a, e.a);
            chk("rd_addr_b", rd_addr_b, e.b);
            chk("tw_addr",   tw_addr,   e.tw);
            chk("wr_en",     wr_en,     e.wr);
            chk("wr_addr_a", wr_addr_a, e.wa);
            chk("wr_addr_b", wr_addr_b, e.wb);
            if (e.busy) chk("stage", stage, e.st);
            if (!rst && start && cyc >= next_free) begin
                predict(cyc);
                next_free = cyc + RUN_CYC + 1;
            end
        end
    end

    // ---------------- data RAM + butterfly model -----------------------------
    typedef struct { int ar; int ai; int br; int bi; } bf_t;
    bf_t bf_q[$];
    int  ram_re [N];
    int  ram_im [N];
    int  x_re   [N];
    int  x_im   [N];
    bit  load = 1'b0;

    initial begin
        bf_t  v;
        real  ang, cw, sw, dr, di;
        for (int i = 0; i < N; i++) begin
            ram_re[i] = 0;
            ram_im[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                bf_q.delete();
            end else begin
                if (load) begin
                    for (int i = 0; i < N; i++) begin
                        ram_re[i] = x_re[i];
                        ram_im[i] = x_im[i];
                    end
                end
                // Synchronous RAM: reads of this cycle see data before its writes.
                if (rd_en) begin
                    ang  = -2.0 * PI * real'(int'(tw_addr)) / real'(N);
                    cw   = $cos(ang);
                    sw   = $sin(ang);
                    dr   = real'(ram_re[rd_addr_a] - ram_re[rd_addr_b]);
                    di   = real'(ram_im[rd_addr_a] - ram_im[rd_addr_b]);
                    v.ar = ram_re[rd_addr_a] + ram_re[rd_addr_b];
                    v.ai = ram_im[rd_addr_a] + ram_im[rd_addr_b];
                    v.br = int'(dr * cw - di * sw);
                    v.bi = int'(dr * sw + di * cw);
                    bf_q.push_back(v);
                end
                if (wr_en && bf_q.size() > 0) begin
                    v = bf_q.pop_front();
                    ram_re[wr_addr_a] = v.ar;
                    ram_im[wr_addr_a] = v.ai;
                    ram_re[wr_addr_b] = v.br;
                    ram_im[wr_addr_b] = v.bi;
                end
            end
        end
    end

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) if (((v >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
        return r;
    endfunction

    task automatic load_vec(input int pos, input int amp);
        for (int n = 0; n < N; n++) begin
            x_re[n] = (n == pos) ? amp : 0;
            x_im[n] = 0;
        end
        @(posedge clk); #1 load = 1'b1;
        @(negedge clk); #1 load = 1'b0;
    endtask

    // One start pulse, optional directed address spot-checks, then DFT compare.
    task automatic run_fft(input int pos, input int amp, input int tol, input bit directed);
        int  t0;
        real sr, si, ang;
        load_vec(pos, amp);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc - 1;
        for (int off = 1; off <= RUN_CYC; off++) begin
            @(negedge clk);
            if (directed) begin
                if (off <= HALF) begin
                    chk("dir_s0_a",  rd_addr_a, off - 1);
                    chk("dir_s0_b",  rd_addr_b, off - 1 + HALF);
                    chk("dir_s0_tw", tw_addr,   off - 1);
                end
                if (off == 15) begin
                    chk("dir_s1j4_a", rd_addr_a, 8);
                    chk("dir_s1j4_b", rd_addr_b, 12);
                    chk("dir_s1j4_tw", tw_addr, 0);
                end
                if (off == 16) begin
                    chk("dir_s1j5_a", rd_addr_a, 9);
                    chk("dir_s1j5_b", rd_addr_b, 13);
                    chk("dir_s1j5_tw", tw_addr, 2);
                end
                if (off == 34) begin
                    chk("dir_s3j3_a", rd_addr_a, 6);
                    chk("dir_s3j3_b", rd_addr_b, 7);
                    chk("dir_s3j3_tw", tw_addr, 0);
                end
            end
            if (off == RUN_CYC - 1) chk("last_wr_en", wr_en, 1);
            if (off == RUN_CYC)     chk("done_pulse", done, 1);
        end
        chk("run_start_cycle", cyc, t0 + RUN_CYC);
        for (int m = 0; m < N; m++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = -2.0 * PI * real'(n * m) / real'(N);
                sr += real'(x_re[n]) * $cos(ang) - real'(x_im[n]) * $sin(ang);
                si += real'(x_re[n]) * $sin(ang) + real'(x_im[n]) * $cos(ang);
            end
            chk_tol("bin_re", ram_re[bitrev(m)], int'(sr), tol);
            chk_tol("bin_im", ram_im[bitrev(m)], int'(si), tol);
        end
        load_vec(0, 0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);

        // End-to-end impulse runs with address spot-checks.
        run_fft(0, 16'h4000, 1, 1'b1);
        repeat (4) @(posedge clk);
        run_fft(1, 16'h0400, 3, 1'b0);
        repeat (4) @(posedge clk);

        // start held high: restarts only once back in IDLE.
        @(posedge clk); #1 start = 1'b1;
        repeat (100) @(posedge clk);
        #1 start = 1'b0;
        repeat (60) @(posedge clk);

        // Random start pulses, many landing while busy.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1 start = ($urandom_range(0, 19) == 0);
        end
        start = 1'b0;
        repeat (60) @(posedge clk);

        // Asynchronous reset mid-run at cycle 15 of a run.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc - 1;
        while (cyc < t0 + 15) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_rd_en", rd_en,     0);
        chk("rst_rd_a",  rd_addr_a, 0);
        chk("rst_rd_b",  rd_addr_b, 0);
        chk("rst_tw",    tw_addr,   0);
        chk("rst_wr_en", wr_en,     0);
        chk("rst_wr_a",  wr_addr_a, 0);
        chk("rst_wr_b",  wr_addr_b, 0);
        chk("rst_stage", stage,     0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (60) @(posedge clk);

        // Fresh full run after the reset.
        run_fft(0, 16'h4000, 1, 1'b1);
        repeat (5) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 The block SHALL have parameter LOG2N, default 4, meaning log2 of transform length N (N = 2**LOG2N, LOG2N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, meaning request to run one in-place N-point radix-2 DIF FFT.
REQ-005 The block SHALL have port busy, output, 1 bit, meaning high while in RUN or DRAIN.
REQ-006 The block SHALL have port done, output, 1 bit, meaning one-cycle completion pulse.
REQ-007 The block SHALL have port rd_en, output, 1 bit, meaning the data-RAM read strobe for butterfly operands.
REQ-008 The block SHALL have ports rd_addr_a and rd_addr_b, output, LOG2N bits each, meaning data-RAM read addresses of operands a and b.
REQ-009 The block SHALL have port tw_addr, output, LOG2N-1 bits, meaning twiddle-ROM index k (W = exp(-j2*pi*k/N)), valid with rd_en.
REQ-010 The block SHALL have port wr_en, output, 1 bit, meaning the data-RAM write strobe for butterfly results.
REQ-011 The block SHALL have ports wr_addr_a and wr_addr_b, output, LOG2N bits each, meaning write addresses for Xa and Xb.
REQ-012 The block SHALL have port stage, output, clog2(LOG2N) bits, meaning the current stage index, for debug and scaling.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-014 In IDLE, start=1 SHALL move the FSM to RUN with stage=0 and j=0; start SHALL be ignored in every other state.
REQ-015 RUN SHALL issue one butterfly per cycle: rd_en=1 with addresses for index j (0..N/2-1), then increment j.
REQ-016 Addressing SHALL be: span = N>>(stage+1); g = j>>(LOG2N-1-stage); k = j & (span-1); rd_addr_a = 2*g*span + k; rd_addr_b = rd_addr_a + span; tw_addr = k<<stage.
REQ-017 After j=N/2-1, RUN SHALL go to DRAIN for exactly 2 cycles with rd_en=0.
REQ-018 At the end of DRAIN, the FSM SHALL go to RUN with stage+1 and j=0, or to DONE if stage=LOG2N-1.
REQ-019 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-020 Write latency SHALL be fixed at 2 cycles (1 RAM read latency + 1 butterfly register): wr_en and wr_addr_a/b in cycle t+2 SHALL equal rd_en and rd_addr_a/b in cycle t.
REQ-021 The 2-cycle DRAIN SHALL guarantee that the last write of a stage lands before the first read of the next stage; no read/write address hazard SHALL be possible.
REQ-022 Total run SHALL be LOG2N*(N/2+2) busy cycles plus 1 DONE cycle; for N=16: start at cycle 0, busy cycles 1..40, done at cycle 41.
REQ-023 Results SHALL be in bit-reversed order in RAM; reordering is out of scope.
REQ-024 When rd_en=0, the address outputs SHALL hold 0; when wr_en=0, the write address outputs SHALL hold 0.

Reset
REQ-025 On asserting rst, the block SHALL immediately force the FSM to IDLE, stage, j and the delay pipeline to 0, and all outputs to 0, including mid-run.
REQ-026 After rst deasserts, the block SHALL issue no writes until a new start, and SHALL emit no partial-run done.

Structure
REQ-027 Shared package fft_pkg SHALL hold LOG2N default, N, the state encoding and the WR_LAT=2 constant.
REQ-028 Address arithmetic (REQ-016) SHALL be a combinational sub-module fft_addr_gen(stage, j) -> addr_a, addr_b, tw_addr.
REQ-029 The 2-stage write delay SHALL be a register pipeline inside fft_ctrl.

Verification (LOG2N=4)
REQ-030 The bench SHALL check: start pulse in IDLE -> stage0 reads (a,b,tw) = (0,8,0),(1,9,1)...(7,15,7) in cycles 1..8.
REQ-031 The bench SHALL check: stage1 -> j=4 gives (8,12,0), j=5 gives (9,13,2); stage3, j=3 gives (6,7,0).
REQ-032 The bench SHALL check: every wr_en/wr_addr equals rd_en/rd_addr delayed 2 cycles; last wr_en at cycle 40; done=1 only at cycle 41; busy=1 in cycles 1..40.
REQ-033 The bench SHALL check: start held high throughout a run -> no restart until IDLE, then a new run begins in the cycle after IDLE samples start.
REQ-034 The bench SHALL check: rst asserted asynchronously at cycle 15 -> all outputs 0 before the next edge; no wr_en or done follows; a later start runs a full 41-cycle sequence.
REQ-035 The bench SHALL check: end-to-end with butterfly and RAM models, a 16-point impulse at x[0]=0x4000 -> all bins equal, after bit-reversal, within 1 LSB of the reference model.
